// File: rtl/seq_fsm.sv
// seq_fsm: run/stop phase sequencer walking 2**STATE_W phases, each held DWELL cycles.
// Ports: clk, rst (async, active-high); start/stop/mode control levels;
//   hold pause request (only with SEQ_FSM_PAUSE_EN); state = phase index,
//   running = RUN or PAUSE, step = first cycle of a new phase, wrap = step on index wrap.
// Optional feature macro: SEQ_FSM_PAUSE_EN adds the hold port and PAUSE state.
module seq_fsm #(
  parameter int STATE_W = 2,
  parameter int DWELL   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
`ifdef SEQ_FSM_PAUSE_EN
  input  logic               hold,
`endif
  output logic [STATE_W-1:0] state,
  output logic               running,
  output logic               step,
  output logic               wrap
);
  // Keep the counter at least one bit wide so DWELL=1 still elaborates.
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
`ifdef SEQ_FSM_PAUSE_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} ctrl_t;
`else
  typedef enum logic {IDLE, RUN} ctrl_t;
`endif
  ctrl_t              ctrl_q;
  logic [STATE_W-1:0] state_q, adv_d;
  logic [CW-1:0]      cnt_q;
  logic               running_q, step_q, wrap_q, wrap_d, last_d, launch_d;
  always_comb begin
    adv_d    = mode ? state_q - 1'b1 : state_q + 1'b1;
    wrap_d   = mode ? (state_q == '0) : (state_q == '1);
    last_d   = cnt_q == CW'(DWELL - 1);
    launch_d = ctrl_q == IDLE && start && !stop;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= IDLE;
      state_q   <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else if (ctrl_q == IDLE || stop) begin
      // IDLE and any stop share the cleared datapath; only a clean start launches.
      ctrl_q    <= launch_d ? RUN : IDLE;
      running_q <= launch_d;
      state_q   <= '0;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
`ifdef SEQ_FSM_PAUSE_EN
    end else if (hold) begin
      ctrl_q <= PAUSE;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
`endif
    end else begin
      // Leaving PAUSE counts like a RUN cycle, so the dwell resumes from the frozen count.
      ctrl_q  <= RUN;
      step_q  <= last_d;
      wrap_q  <= last_d && wrap_d;
      state_q <= last_d ? adv_d : state_q;
      cnt_q   <= last_d ? '0 : cnt_q + 1'b1;
    end
  end
  assign state   = state_q;
  assign running = running_q;
  assign step    = step_q;
  assign wrap    = wrap_q;
endmodule

// File: tb/tb_seq_fsm.sv
// tb_seq_fsm: directed table-driven bench for seq_fsm (STATE_W=2, DWELL=2).
`timescale 1ns/1ps
module tb_seq_fsm;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
`ifdef SEQ_FSM_PAUSE_EN
  logic       hold = 1'b0;
`endif
  logic [1:0] state;
  logic       running, step, wrap;
  int         nvec = 0, nerr = 0;
  typedef struct {
    logic       start, stop, mode;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[28];
  always #50 clk = ~clk;
  seq_fsm #(.STATE_W(2), .DWELL(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
`ifdef SEQ_FSM_PAUSE_EN
    .hold(hold),
`endif
    .state(state), .running(running), .step(step), .wrap(wrap)
  );
  function automatic vec_t v(input logic s, p, m, input logic [1:0] st, input logic r, sp, w);
    vec_t x;
    x.start = s;
    x.stop  = p;
    x.mode  = m;
    x.exp   = {st, r, sp, w};
    return x;
  endfunction
  task automatic check(input string name, input logic [4:0] exp);
    nvec++;
    if ({state, running, step, wrap} !== exp) begin
      nerr++;
      $display("FAIL %s: got state/running/step/wrap=%b required %b", name, {state, running, step, wrap}, exp);
    end
  endtask
  task automatic cyc(input logic s, p, m);
    start = s;
    stop  = p;
    mode  = m;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = v(1,0,0, 0,1,0,0);
    tbl[1]  = v(0,0,0, 0,1,0,0);
    tbl[2]  = v(0,0,0, 1,1,1,0);
    tbl[3]  = v(0,0,0, 1,1,0,0);
    tbl[4]  = v(0,0,0, 2,1,1,0);
    tbl[5]  = v(0,0,0, 2,1,0,0);
    tbl[6]  = v(0,0,0, 3,1,1,0);
    tbl[7]  = v(0,0,0, 3,1,0,0);
    tbl[8]  = v(0,0,0, 0,1,1,1);
    tbl[9]  = v(0,0,0, 0,1,0,0);
    tbl[10] = v(0,0,0, 1,1,1,0);
    tbl[11] = v(0,0,0, 1,1,0,0);
    tbl[12] = v(0,0,0, 2,1,1,0);
    tbl[13] = v(0,0,1, 2,1,0,0);
    tbl[14] = v(0,0,1, 1,1,1,0);
    tbl[15] = v(0,0,1, 1,1,0,0);
    tbl[16] = v(0,0,1, 0,1,1,0);
    tbl[17] = v(0,0,1, 0,1,0,0);
    tbl[18] = v(0,0,1, 3,1,1,1);
    tbl[19] = v(1,0,1, 3,1,0,0);
    tbl[20] = v(0,0,1, 2,1,1,0);
    tbl[21] = v(1,1,1, 0,0,0,0);
    tbl[22] = v(1,1,0, 0,0,0,0);
    tbl[23] = v(1,0,0, 0,1,0,0);
    tbl[24] = v(0,0,0, 0,1,0,0);
    tbl[25] = v(0,0,0, 1,1,1,0);
    tbl[26] = v(0,1,0, 0,0,0,0);
    tbl[27] = v(0,0,0, 0,0,0,0);
    #10 rst = 1'b1;
    #1 check("reset_async", 5'b0);
    @(posedge clk);
    #1 check("reset_held", 5'b0);
    #20 rst = 1'b0;
    @(posedge clk);
    #1 check("after_release", 5'b0);
    for (int i = 0; i < 28; i++) begin
      cyc(tbl[i].start, tbl[i].stop, tbl[i].mode);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    cyc(1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0);
    check("pre_reset_s3", {2'd3, 1'b1, 1'b1, 1'b0});
    #30 rst = 1'b1;
    #1 check("rst_mid_cycle", 5'b0);
    #10 rst = 1'b0;
    cyc(0, 0, 0);
    check("idle_after_rst", 5'b0);
    cyc(1, 0, 0);
    check("relaunch_p0a", {2'd0, 1'b1, 1'b0, 1'b0});
    cyc(0, 0, 0);
    check("relaunch_p0b", {2'd0, 1'b1, 1'b0, 1'b0});
    cyc(0, 0, 0);
    check("relaunch_p1", {2'd1, 1'b1, 1'b1, 1'b0});
    cyc(0, 1, 0);
    check("stop_after_rst", 5'b0);
`ifdef SEQ_FSM_PAUSE_EN
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("pause_pre", {2'd1, 1'b1, 1'b1, 1'b0});
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      check($sformatf("pause_hold%0d", i), {2'd1, 1'b1, 1'b0, 1'b0});
    end
    hold = 1'b0;
    cyc(0, 0, 0);
    check("pause_resume", {2'd1, 1'b1, 1'b0, 1'b0});
    cyc(0, 0, 0);
    check("pause_adv", {2'd2, 1'b1, 1'b1, 1'b0});
    hold = 1'b1;
    cyc(0, 0, 0);
    check("pause_again", {2'd2, 1'b1, 1'b0, 1'b0});
    cyc(0, 1, 0);
    check("pause_stop", 5'b0);
    hold = 1'b0;
    cyc(0, 0, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
